// File: rtl/platform_pkg.sv
// Platform-wide constants and shared types for the Wishbone interconnect.
package platform_pkg;

    localparam int NUM_MASTERS        = 2;
    localparam int CORE_MASTER_INDEX  = 0;
    localparam int DBG_MASTER_INDEX   = 1;
    localparam int WB_TIMEOUT_CYCLES  = 255;
    localparam int WB_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_OWNED     = 2'd1,
        ARB_DRAIN_ERR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr wins.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    int idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter with cycle lock, outstanding limit
// and a no-ack watchdog. state_o exposes the FSM for debug.
module wb_bus_arbiter #(
    parameter int NUM_MASTERS     = platform_pkg::NUM_MASTERS,
    parameter int TIMEOUT_CYCLES  = platform_pkg::WB_TIMEOUT_CYCLES,
    parameter int MAX_OUTSTANDING = platform_pkg::WB_MAX_OUTSTANDING
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_adr_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_dat_i,
    input  logic [NUM_MASTERS-1:0][3:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]      m_stall_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [31:0]                 m_dat_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [31:0]                 s_adr_o,
    output logic [31:0]                 s_dat_o,
    output logic [3:0]                  s_sel_o,
    input  logic                        s_stall_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic [31:0]                 s_dat_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o,
    output logic [1:0]                  state_o
);
    import platform_pkg::*;

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE      = ARB_IDLE;
    localparam logic [1:0] OWNED     = ARB_OWNED;
    localparam logic [1:0] DRAIN_ERR = ARB_DRAIN_ERR;

    localparam logic [PW-1:0] LAST_MASTER = PW'(NUM_MASTERS - 1);

    logic [1:0]             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [PW-1:0]          owner;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          next_ptr;
    logic [OW-1:0]          outstanding;
    logic [WW-1:0]          wdog;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [PW-1:0]          pick_idx;

    logic owned, owner_cyc, full, counting, fire, resp_ok, accept, dec;

    rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
        .req   (m_cyc_i),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_gnt[i]) pick_idx = PW'(i);
        end
    end

    assign owned     = (state == OWNED);
    assign owner_cyc = m_cyc_i[owner];
    assign full      = (outstanding == OW'(MAX_OUTSTANDING));
    assign counting  = owned && (outstanding != '0) && !(s_ack_i || s_err_i);
    assign fire      = counting && (wdog == WW'(TIMEOUT_CYCLES - 1));
    // Responses with nothing outstanding, or after the owner let go of cyc, are dropped.
    assign resp_ok   = owned && owner_cyc && (outstanding != '0);
    assign dec       = resp_ok && (s_ack_i || s_err_i);
    assign next_ptr  = (owner == LAST_MASTER) ? '0 : owner + 1'b1;

    assign s_cyc_o   = owned && owner_cyc && !fire;
    assign s_stb_o   = s_cyc_o && m_stb_i[owner] && !full;
    assign accept    = s_stb_o && !s_stall_i;
    assign s_we_o    = m_we_i[owner];
    assign s_adr_o   = m_adr_i[owner];
    assign s_dat_o   = m_dat_i[owner];
    assign s_sel_o   = m_sel_i[owner];
    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant;
    assign timeout_o = fire;
    assign state_o   = state;

    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        if (owned && !fire) m_stall_o[owner] = s_stall_i || full;
        if (resp_ok) begin
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = s_err_i;
        end
        if (fire) m_err_o[owner] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            ptr         <= '0;
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    wdog        <= '0;
                    if (pick_valid) begin
                        state <= OWNED;
                        grant <= pick_gnt;
                        owner <= pick_idx;
                    end
                end
                OWNED: begin
                    if (!owner_cyc) begin
                        state       <= IDLE;
                        grant       <= '0;
                        ptr         <= next_ptr;
                        outstanding <= '0;
                        wdog        <= '0;
                    end else if (fire) begin
                        state       <= DRAIN_ERR;
                        outstanding <= '0;
                        wdog        <= '0;
                    end else begin
                        if (accept && !dec)      outstanding <= outstanding + OW'(1);
                        else if (dec && !accept) outstanding <= outstanding - OW'(1);
                        wdog <= counting ? wdog + WW'(1) : '0;
                    end
                end
                DRAIN_ERR: begin
                    if (!owner_cyc) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with hand-computed expectations.
module tb_wb_bus_arbiter;

    localparam int NM = 2;
    localparam int TO = 8;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NM-1:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [NM-1:0][31:0]  m_adr_i, m_dat_i;
    logic [NM-1:0][3:0]   m_sel_i;
    logic [NM-1:0]        m_stall_o, m_ack_o, m_err_o;
    logic [31:0]          m_dat_o;
    logic                 s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]          s_adr_o, s_dat_o;
    logic [3:0]           s_sel_o;
    logic                 s_stall_i, s_ack_i, s_err_i;
    logic [31:0]          s_dat_i;
    logic [NM-1:0]        grant_o;
    logic                 timeout_o;
    logic [1:0]           state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_stall_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [12:0] stall_tab;
        logic [12:0] ack_tab;
        int sent;
        int acks;

        idle_inputs();
        do_reset();

        // reset values
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        check("rst_stall", 32'(m_stall_o), 32'h3);
        check("rst_ack", 32'(m_ack_o), 32'h0);
        check("rst_err", 32'(m_err_o), 32'h0);
        check("rst_scyc", 32'(s_cyc_o), 32'h0);
        check("rst_sstb", 32'(s_stb_o), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);

        // single owner, three pipelined reads
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0] = 32'h9000_0000;
        settle();
        check("t1_idle_grant", 32'(grant_o), 32'h0);
        check("t1_idle_stall", 32'(m_stall_o), 32'h3);
        step();
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_scyc", 32'(s_cyc_o), 32'h1);
        check("t1_sstb", 32'(s_stb_o), 32'h1);
        check("t1_sadr0", s_adr_o, 32'h9000_0000);
        check("t1_stall", 32'(m_stall_o), 32'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) m_adr_i[0] = 32'h9000_0000 + 32'(4 * (k + 1));
            else m_stb_i[0] = 1'b0;
            s_ack_i = 1'b1;
            s_dat_i = 32'hD000_0000 + 32'(k);
            exp_q.push_back(32'hD000_0000 + 32'(k));
            settle();
            check("t1_ack", 32'(m_ack_o), 32'h1);
            check("t1_dat", m_dat_o, exp_q.pop_front());
            if (k < 2) check("t1_sadr", s_adr_o, 32'h9000_0000 + 32'(4 * (k + 1)));
            check("t1_m1_stall", 32'(m_stall_o[1]), 32'h1);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0;
        settle();
        check("t1_noack", 32'(m_ack_o), 32'h0);
        check("t1_scyc_drop", 32'(s_cyc_o), 32'h0);
        step();
        check("t1_release", 32'(grant_o), 32'h0);

        // simultaneous request after reset
        do_reset();
        m_cyc_i = 2'b11;
        step();
        check("t2_m0_first", 32'(grant_o), 32'h1);
        m_cyc_i[0] = 1'b0;
        step();
        check("t2_idle", 32'(grant_o), 32'h0);
        step();
        check("t2_m1_next", 32'(grant_o), 32'h2);
        m_cyc_i[1] = 1'b0;
        step();
        m_cyc_i = 2'b11;
        step();
        check("t2_ptr_zero", 32'(grant_o), 32'h1);
        m_cyc_i = 2'b00;
        step();

        // lock: m1 owns, m0 requests mid-cycle
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
        m_adr_i[1] = 32'hA000_0010; m_dat_i[1] = 32'h1234_5678; m_sel_i[1] = 4'hF;
        step();
        check("t3_grant", 32'(grant_o), 32'h2);
        check("t3_swe", 32'(s_we_o), 32'h1);
        check("t3_sadr", s_adr_o, 32'hA000_0010);
        check("t3_sdat", s_dat_o, 32'h1234_5678);
        check("t3_ssel", 32'(s_sel_o), 32'hF);
        step();
        m_stb_i[1] = 1'b0; s_ack_i = 1'b1; m_cyc_i[0] = 1'b1;
        settle();
        check("t3_ack", 32'(m_ack_o), 32'h2);
        check("t3_stall", 32'(m_stall_o), 32'h1);
        step();
        s_ack_i = 1'b0;
        settle();
        check("t3_locked", 32'(grant_o), 32'h2);
        check("t3_stall2", 32'(m_stall_o), 32'h1);
        m_cyc_i[1] = 1'b0; m_we_i[1] = 1'b0;
        step();
        check("t3_idle", 32'(grant_o), 32'h0);
        check("t3_idle_stall", 32'(m_stall_o), 32'h3);
        step();
        check("t3_m0_grant", 32'(grant_o), 32'h1);
        m_cyc_i[0] = 1'b0;
        step();

        // outstanding limit: six strobes, late acks
        stall_tab = 13'h02B0;
        ack_tab   = 13'h1EA0;
        sent = 0;
        acks = 0;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0] = 32'h9000_0100;
        step();
        for (int c = 0; c < 13; c++) begin
            s_ack_i = ack_tab[c];
            m_stb_i[0] = (sent < 6);
            settle();
            check($sformatf("t4_stall_c%0d", c), 32'(m_stall_o[0]), 32'(stall_tab[c]));
            if (c == 4) check("t4_stb_held", 32'(s_stb_o), 32'h0);
            if (m_ack_o[0]) acks++;
            if (s_stb_o && !s_stall_i) sent++;
            step();
        end
        s_ack_i = 1'b1; m_stb_i[0] = 1'b0;
        settle();
        check("t4_stray_ack", 32'(m_ack_o), 32'h0);
        check("t4_acks", 32'(acks), 32'd6);
        check("t4_sent", 32'(sent), 32'd6);
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0;
        step();

        // watchdog timeout
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0] = 32'hA000_0020;
        step();
        check("t5_grant", 32'(grant_o), 32'h1);
        step();
        m_stb_i[0] = 1'b0;
        for (int n = 1; n < 8; n++) begin
            settle();
            check($sformatf("t5_err_c%0d", n), 32'(m_err_o), 32'h0);
            check($sformatf("t5_to_c%0d", n), 32'(timeout_o), 32'h0);
            check($sformatf("t5_cyc_c%0d", n), 32'(s_cyc_o), 32'h1);
            step();
        end
        settle();
        check("t5_err_fire", 32'(m_err_o), 32'h1);
        check("t5_to_fire", 32'(timeout_o), 32'h1);
        check("t5_cyc_fire", 32'(s_cyc_o), 32'h0);
        step();
        s_ack_i = 1'b1;
        settle();
        check("t5_to_pulse", 32'(timeout_o), 32'h0);
        check("t5_err_once", 32'(m_err_o), 32'h0);
        check("t5_late_ack", 32'(m_ack_o), 32'h0);
        check("t5_drain_cyc", 32'(s_cyc_o), 32'h0);
        check("t5_drain_stall", 32'(m_stall_o), 32'h3);
        check("t5_drain_state", 32'(state_o), 32'h2);
        step();
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0;
        step();
        check("t5_released", 32'(grant_o), 32'h0);

        // reset mid-transaction
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0] = 32'h9000_0200;
        step();
        step();
        step();
        m_stb_i[0] = 1'b0;
        settle();
        check("t6_cyc_before", 32'(s_cyc_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_cyc_async", 32'(s_cyc_o), 32'h0);
        check("t6_grant_async", 32'(grant_o), 32'h0);
        check("t6_stall_async", 32'(m_stall_o), 32'h3);
        step();
        step();
        rst = 1'b0;
        m_cyc_i = 2'b10;
        settle();
        check("t6_idle", 32'(grant_o), 32'h0);
        step();
        check("t6_m1_grant", 32'(grant_o), 32'h2);
        check("t6_m1_cyc", 32'(s_cyc_o), 32'h1);
        m_cyc_i = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single platform Wishbone B4 pipelined bus between NUM_MASTERS requesters: core data port (master 0) and debug/DMA port (master 1).
- Sits between the masters and the address decoder that fans out to DMEM, MTIMER, LED driver and WBUART.
- Provides round-robin arbitration, ownership locked for a whole cycle, outstanding-request tracking, and a bus-timeout watchdog that returns err when a slave never acks.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT_CYCLES, 255, cycles with outstanding>0 and no ack/err before a timeout is declared.
- MAX_OUTSTANDING, 4, max un-acked strobes accepted per ownership.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master cyc
- m_stb_i  in  NUM_MASTERS  per-master stb
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS x 32  per-master address
- m_dat_i  in  NUM_MASTERS x 32  per-master write data
- m_sel_i  in  NUM_MASTERS x 4  per-master byte select
- m_stall_o  out  NUM_MASTERS  per-master stall
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master err
- m_dat_o  out  32  read data, broadcast; valid only with that master's ack
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to decoder
- s_adr_o  out  32  to decoder
- s_dat_o  out  32  to decoder
- s_sel_o  out  4  to decoder
- s_stall_i, s_ack_i, s_err_i  in  1 each  from decoder
- s_dat_i  in  32  read data from decoder
- grant_o  out  NUM_MASTERS  one-hot current owner (0 when idle)
- timeout_o  out  1  one-cycle pulse on watchdog fire

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - grant_o=0, timeout_o=0.
  - All m_ack_o/m_err_o=0; m_stall_o all 1.
  - s_cyc_o=0, s_stb_o=0.
  - Round-robin pointer = master 0; outstanding=0; watchdog=0.
- FSM states: IDLE, OWNED, DRAIN_ERR.
- IDLE:
  - Scan m_cyc_i starting at the pointer; the first asserted master wins.
  - Grant registers next cycle (1-cycle arbitration latency). Go to OWNED.
  - No requester: stay in IDLE.
- OWNED:
  - s_* outputs are combinationally muxed from the owner: s_cyc_o=m_cyc_i[owner].
  - m_stall_o[owner]=s_stall_i OR (outstanding==MAX_OUTSTANDING). Non-owners see stall=1, ack=0, err=0.
  - s_stb_o is suppressed while outstanding==MAX_OUTSTANDING.
  - s_ack_i/s_err_i are routed to the owner only.
- Outstanding counter:
  - +1 on an accepted strobe (s_stb_o & ~s_stall_i).
  - −1 on s_ack_i|s_err_i. Both in the same cycle: unchanged.
  - Width is clog2(MAX_OUTSTANDING+1). Never underflows: an ack with outstanding==0 is ignored and not forwarded.
- Release:
  - When the owner drops cyc, go to IDLE next cycle and set pointer = owner+1 mod NUM_MASTERS.
  - Outstanding is cleared. Dropping cyc with acks pending abandons them, per the Wishbone rule.
- Lock: a higher-priority request never preempts an active owner.
- Watchdog:
  - Counts while outstanding>0 and no s_ack_i/s_err_i. Reset to 0 on any ack/err or when outstanding==0.
  - On reaching TIMEOUT_CYCLES: pulse timeout_o, assert m_err_o[owner] for one cycle, force s_cyc_o=0, go to DRAIN_ERR.
- DRAIN_ERR:
  - s_cyc_o held 0; owner stalled.
  - Wait for the owner to drop cyc, then go to IDLE with the pointer advanced.
  - Late s_ack_i in this state is discarded.
- Simultaneous requests in IDLE: the pointer decides. A request arriving in the same cycle the owner releases is considered in the next IDLE cycle.
- Reset mid-transaction: immediate return to reset values; s_cyc_o drops asynchronously.

Decomposition:
- Add to platform_pkg: NUM_MASTERS, CORE_MASTER_INDEX=0, DBG_MASTER_INDEX=1, WB_TIMEOUT_CYCLES, and the arbiter state enum typedef.
- One sub-module, rr_picker: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and valid.

Test Plan:
- Single owner: m0 cyc, 3 pipelined reads to 0x9000_0000/4/8, slave acks 1 cycle later each -> grant_o=01, 3 acks to m0 with correct data, m1 sees stall=1 and no acks.
- Simultaneous request: m0 and m1 cyc asserted in the same IDLE cycle after reset -> m0 granted. After m0 drops cyc, m1 is granted with no further request and the pointer = 0 afterwards.
- Lock: m1 owns and issues a write to 0xA000_0010; m0 requests mid-cycle -> m0 stalled until m1 drops cyc, then granted 1 cycle after IDLE.
- Outstanding limit: m0 issues 6 strobes, slave never stalls and acks late -> 5th strobe stalled until the first ack; 6 acks in total, counter returns to 0.
- Timeout: m0 reads 0xA000_0020, slave silent with TIMEOUT_CYCLES=8 -> err to m0 exactly 8 cycles after the strobe is accepted, timeout_o single pulse, s_cyc_o low; a later stray ack is not forwarded.
- Reset mid-transaction: assert rst_i with 2 outstanding -> s_cyc_o=0 immediately, grant_o=0; after release, m1 requests alone and is granted normally.
